sha256_ctrl: RTL and testbench

Block-level sequencer for the SHA-256 datapath. Accepts 512-bit blocks from `sha256_msgbuf` via its `block_ready`/`parser_ready` handshake and launches the 64-round compression core once per block. Holds the running hash H0..H7, initialised from the FIPS 180-4 IV, and performs the per-block modular accumulation. Presents the final 256-bit digest after the last padded block.

---
 rtl/sha256_ctrl_if.sv | 34 +++
 rtl/sha256_ctrl.sv | 125 ++++++++++++
 tb/tb_sha256_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_ctrl_if.sv
// sha256_ctrl_if
//   Groups the controller's block handshake, compression-core link and digest
//   outputs into one bundle.
//   master : environment side (message buffer, compression core, digest consumer)
//   slave  : the sha256_ctrl sequencer
//   Signals:
//     start, block_ready, block_last          : message/block control in
//     parser_ready                            : controller can take a block
//     core_start, core_hash_in                : launch pulse and current H to core
//     core_done, core_hash_out                : core completion and working vars a..h
//     digest, digest_valid, busy              : result and status
interface sha256_ctrl_if;
  logic         start;
  logic         block_ready;
  logic         block_last;
  logic         parser_ready;
  logic         core_start;
  logic [255:0] core_hash_in;
  logic         core_done;
  logic [255:0] core_hash_out;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  modport master (
    output start, block_ready, block_last, core_done, core_hash_out,
    input  parser_ready, core_start, core_hash_in, digest, digest_valid, busy
  );

  modport slave (
    input  start, block_ready, block_last, core_done, core_hash_out,
    output parser_ready, core_start, core_hash_in, digest, digest_valid, busy
  );
endinterface

// File: rtl/sha256_ctrl.sv
// sha256_ctrl
//   Block-level sequencer for the SHA-256 datapath. Takes padded 512-bit blocks
//   from the message buffer, launches the 64-round compression core once per
//   block, accumulates the core result into the running hash H0..H7 and
//   presents the digest after the last block.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : sha256_ctrl_if.slave (handshake, core link, digest/status)
//   H0 occupies [255:224], H7 occupies [31:0] on every 256-bit bus.
module sha256_ctrl (
  input  logic         clk,
  input  logic         rst,
  sha256_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    RUN,
    ACCUM,
    DONE
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  state_t       state;
  logic [255:0] h;
  logic [255:0] work;
  logic         last_q;
  logic         parser_ready;
  logic         core_start;
  logic         digest_valid;
  logic         busy;

  // Eight independent 32-bit modular adds; carries are dropped per word.
  function automatic logic [255:0] add_words(input logic [255:0] a,
                                             input logic [255:0] b);
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    end
    return s;
  endfunction

  // Status outputs are registered alongside the state so that each one is
  // already correct in the first cycle of the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      h            <= '0;
      work         <= '0;
      last_q       <= 1'b0;
      parser_ready <= 1'b0;
      core_start   <= 1'b0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            h            <= IV;
            state        <= WAIT_BLK;
            parser_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        WAIT_BLK: begin
          if (bus.block_ready && parser_ready) begin
            last_q       <= bus.block_last;
            state        <= RUN;
            parser_ready <= 1'b0;
            core_start   <= 1'b1;
          end
        end
        RUN: begin
          // core_done may coincide with the launch cycle for a fast core.
          if (bus.core_done) begin
            work  <= bus.core_hash_out;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          h <= add_words(h, work);
          if (last_q) begin
            state        <= DONE;
            busy         <= 1'b0;
            digest_valid <= 1'b1;
          end else begin
            state        <= WAIT_BLK;
            parser_ready <= 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            h            <= IV;
            state        <= WAIT_BLK;
            digest_valid <= 1'b0;
            parser_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          parser_ready <= 1'b0;
          digest_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.parser_ready = parser_ready;
  assign bus.core_start   = core_start;
  assign bus.core_hash_in = h;
  assign bus.digest       = h;
  assign bus.digest_valid = digest_valid;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl
//   Self-checking bench for sha256_ctrl. Expected digests are queued when a
//   message is driven and compared when digest_valid rises.
module tb_sha256_ctrl;

  localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] WRAP  = 256'h00000000bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IVP1  = 256'h6a09e668bb67ae863c6ef373a54ff53b510e52809b05688d1f83d9ac5be0cd1a;
  localparam logic [255:0] CLEAN = 256'h7a09e667cb67ae854c6ef372b54ff53a610e527fab05688c2f83d9ab6be0cd19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_ctrl_if bus();
  sha256_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cyc = 0;
  int cs_count = 0;
  int cs0      = 0;
  logic [255:0] sb[$];
  logic dv_prev = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.core_start) cs_count++;
  end

  // Scoreboard: pop one expected digest on every rising edge of digest_valid.
  always @(negedge clk) begin
    logic [255:0] exp;
    if (bus.digest_valid && !dv_prev) begin
      check("sb_nonempty", 256'(sb.size() > 0), 256'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("digest", bus.digest, exp);
        check("dv_latency", 256'(cyc - done_cyc), 256'd1);
      end
    end
    dv_prev = bus.digest_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_pr();
    for (int i = 0; i < 200; i++) begin
      if (bus.parser_ready) break;
      @(negedge clk);
    end
    check("wait_parser_ready", 256'(bus.parser_ready), 256'd1);
  endtask

  task automatic wait_dv();
    for (int i = 0; i < 200; i++) begin
      if (bus.digest_valid) break;
      @(negedge clk);
    end
    check("wait_digest_valid", 256'(bus.digest_valid), 256'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_parser_ready"}, 256'(bus.parser_ready), 256'd0);
    check({tag, "_core_start"},   256'(bus.core_start),   256'd0);
    check({tag, "_digest_valid"}, 256'(bus.digest_valid), 256'd0);
    check({tag, "_busy"},         256'(bus.busy),         256'd0);
    check({tag, "_digest"},       bus.digest,             256'd0);
    check({tag, "_core_hash_in"}, bus.core_hash_in,       256'd0);
  endtask

  // One block: handshake, check launch, let the core answer after lat cycles.
  task automatic run_block(input logic last, input logic [255:0] ret,
                           input int lat, input logic [255:0] exp_hin);
    wait_pr();
    bus.block_ready = 1'b1;
    bus.block_last  = last;
    @(negedge clk);
    bus.block_ready = 1'b0;
    bus.block_last  = 1'b0;
    check("core_start", 256'(bus.core_start), 256'd1);
    check("core_hash_in", bus.core_hash_in, exp_hin);
    check("run_parser_ready", 256'(bus.parser_ready), 256'd0);
    repeat (lat - 1) @(negedge clk);
    bus.core_done     = 1'b1;
    bus.core_hash_out = ret;
    @(negedge clk);
    done_cyc          = cyc;
    bus.core_done     = 1'b0;
    bus.core_hash_out = '0;
  endtask

  initial begin
    bus.start = 1'b0; bus.block_ready = 1'b0; bus.block_last = 1'b0;
    bus.core_done = 1'b0; bus.core_hash_out = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 256'(bus.busy), 256'd0);

    // Single block, core returns zeros: digest equals IV.
    pulse_start();
    check("start_parser_ready", 256'(bus.parser_ready), 256'd1);
    check("start_busy", 256'(bus.busy), 256'd1);
    check("start_hash_in", bus.core_hash_in, IV);
    cs0 = cs_count;
    sb.push_back(IV);
    run_block(1'b1, '0, 64, IV);
    wait_dv();
    check("single_cs_pulses", 256'(cs_count - cs0), 256'd1);
    check("done_busy", 256'(bus.busy), 256'd0);

    // Restart from DONE, then a modular wrap in H0 only.
    check("done_digest_valid", 256'(bus.digest_valid), 256'd1);
    pulse_start();
    check("restart_digest_valid", 256'(bus.digest_valid), 256'd0);
    check("restart_hash_in", bus.core_hash_in, IV);
    check("restart_parser_ready", 256'(bus.parser_ready), 256'd1);
    sb.push_back(WRAP);
    run_block(1'b1, {32'h95f61999, 224'h0}, 5, IV);
    wait_dv();
    check("wrap_h1", 256'(bus.digest[223:192]), 256'(32'hbb67ae85));

    // Two blocks: intermediate hash feeds the second launch.
    pulse_start();
    cs0 = cs_count;
    sb.push_back(IVP1);
    run_block(1'b0, {8{32'h00000001}}, 10, IV);
    run_block(1'b1, '0, 3, IVP1);
    wait_dv();
    check("two_cs_pulses", 256'(cs_count - cs0), 256'd2);

    // Ignored events: core_done in WAIT_BLK, start in RUN, block_ready held high.
    pulse_start();
    cs0 = cs_count;
    sb.push_back(IV);
    bus.core_done = 1'b1;
    bus.core_hash_out = {8{32'hdeadbeef}};
    @(negedge clk);
    bus.core_done = 1'b0;
    bus.core_hash_out = '0;
    @(negedge clk);
    check("wb_done_parser_ready", 256'(bus.parser_ready), 256'd1);
    check("wb_done_hash_in", bus.core_hash_in, IV);
    check("wb_done_busy", 256'(bus.busy), 256'd1);
    bus.block_ready = 1'b1;
    bus.block_last  = 1'b0;
    @(negedge clk);
    check("held_core_start1", 256'(bus.core_start), 256'd1);
    pulse_start();
    check("run_start_hash_in", bus.core_hash_in, IV);
    check("run_start_parser_ready", 256'(bus.parser_ready), 256'd0);
    check("run_start_busy", 256'(bus.busy), 256'd1);
    @(negedge clk);
    bus.core_done  = 1'b1;
    bus.block_last = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    @(negedge clk);
    check("accum_parser_ready", 256'(bus.parser_ready), 256'd1);
    @(negedge clk);
    check("held_core_start2", 256'(bus.core_start), 256'd1);
    bus.block_ready = 1'b0;
    bus.block_last  = 1'b0;
    bus.core_done   = 1'b1;
    @(negedge clk);
    done_cyc      = cyc;
    bus.core_done = 1'b0;
    wait_dv();
    check("held_cs_pulses", 256'(cs_count - cs0), 256'd2);

    // Asynchronous reset in the middle of RUN, then a late core_done.
    pulse_start();
    wait_pr();
    bus.block_ready = 1'b1;
    bus.block_last  = 1'b1;
    @(negedge clk);
    bus.block_ready = 1'b0;
    bus.block_last  = 1'b0;
    check("abort_core_start", 256'(bus.core_start), 256'd1);
    repeat (3) @(negedge clk);
    check("abort_busy", 256'(bus.busy), 256'd1);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.core_done = 1'b1;
    bus.core_hash_out = {8{32'h12345678}};
    @(negedge clk);
    bus.core_done = 1'b0;
    bus.core_hash_out = '0;
    repeat (3) @(negedge clk);
    check_zero("late_done");

    // Clean single-block hash after the abort.
    pulse_start();
    cs0 = cs_count;
    sb.push_back(CLEAN);
    run_block(1'b1, {8{32'h10000000}}, 7, IV);
    wait_dv();
    check("clean_cs_pulses", 256'(cs_count - cs0), 256'd1);

    repeat (2) @(negedge clk);
    check("sb_drained", 256'(sb.size()), 256'd0);
    check("cs_total", 256'(cs_count), 256'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
